// File: rtl/vend_arbiter_if.sv
// Bundle of signals between two coin requesters, the arbiter and the shared vending core.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface vend_arbiter_if;
    logic [1:0] req0_coin;
    logic [1:0] req1_coin;
    logic [1:0] gnt;
    logic [1:0] core_coin;
    logic       core_rstn;
    logic       core_sell;
    logic [1:0] core_change;
    logic       sell0;
    logic       sell1;
    logic [1:0] change0;
    logic [1:0] change1;
    logic       refund_vld;
    logic       refund_who;
    logic [2:0] refund_amt;

    modport slave (
        input  req0_coin, req1_coin, core_sell, core_change,
        output gnt, core_coin, core_rstn, sell0, sell1, change0, change1,
               refund_vld, refund_who, refund_amt
    );

    modport master (
        output req0_coin, req1_coin, core_sell, core_change,
        input  gnt, core_coin, core_rstn, sell0, sell1, change0, change1,
               refund_vld, refund_who, refund_amt
    );
endinterface

// File: rtl/vend_arbiter.sv
// Round-robin arbiter that shares one vending core between two coin requesters,
// forwarding coins, routing sell/change back and refunding credit on idle timeout.
module vend_arbiter #(
    parameter int TIMEOUT = 16
) (
    input logic          clk,
    input logic          rstn,
    vend_arbiter_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] OWN0  = 3'd1;
    localparam logic [2:0] OWN1  = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] FLUSH = 3'd4;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [2:0] state, state_nxt;
    logic       owner;
    logic       ptr;
    logic [2:0] credit;
    logic [7:0] timer;

    logic [1:0] core_coin_p1;
    logic       core_rstn_p1;
    logic       sell0_p1, sell1_p1;
    logic [1:0] change0_p1, change1_p1;

    logic       owning, ok0, ok1, pick, accept, sell_now, timed_out;
    logic [1:0] own_coin;

    function automatic logic coin_legal(input logic [1:0] coin);
        return (coin == 2'b01) || (coin == 2'b10);
    endfunction

    // Coin code doubles as its value in half-units.
    function automatic logic [2:0] credit_sat_add(input logic [2:0] acc, input logic [1:0] coin);
        logic [3:0] sum;
        sum = {1'b0, acc} + {2'b00, coin};
        return (sum > 4'd7) ? 3'd7 : sum[2:0];
    endfunction

    always_comb begin
        owning    = (state == OWN0) || (state == OWN1);
        own_coin  = owner ? bus.req1_coin : bus.req0_coin;
        ok0       = coin_legal(bus.req0_coin);
        ok1       = coin_legal(bus.req1_coin);
        pick      = (ok0 && ok1) ? ~ptr : ok1;
        accept    = owning && coin_legal(own_coin) && !bus.core_sell;
        sell_now  = owning && bus.core_sell;
        timed_out = owning && !bus.core_sell && !accept && (timer == TMO_LAST);

        state_nxt = state;
        case (state)
            IDLE:       if (ok0 || ok1) state_nxt = pick ? OWN1 : OWN0;
            OWN0, OWN1: begin
                if (bus.core_sell)  state_nxt = DONE;
                else if (timed_out) state_nxt = FLUSH;
            end
            DONE, FLUSH: state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    // Stage p0 -> p1: arbitration state and registered core/requester outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            ptr          <= 1'b1;  // "last served = 1" lets requester 0 win the first tie
            owner        <= 1'b0;
            credit       <= 3'd0;
            timer        <= 8'd0;
            core_coin_p1 <= 2'b00;
            core_rstn_p1 <= 1'b0;
            sell0_p1     <= 1'b0;
            sell1_p1     <= 1'b0;
            change0_p1   <= 2'b00;
            change1_p1   <= 2'b00;
        end else begin
            state        <= state_nxt;
            core_rstn_p1 <= (state_nxt != FLUSH);
            core_coin_p1 <= accept ? own_coin : 2'b00;
            sell0_p1     <= sell_now && !owner;
            sell1_p1     <= sell_now && owner;
            change0_p1   <= (sell_now && !owner) ? bus.core_change : 2'b00;
            change1_p1   <= (sell_now && owner)  ? bus.core_change : 2'b00;

            if (state == IDLE && (ok0 || ok1)) begin
                owner  <= pick;
                credit <= 3'd0;
                timer  <= 8'd0;
            end else if (accept) begin
                credit <= credit_sat_add(credit, own_coin);
                timer  <= 8'd0;
            end else if (owning) begin
                timer  <= timer + 8'd1;
            end

            if (sell_now || state == FLUSH) ptr <= owner;
        end
    end

    always_comb begin
        bus.gnt         = (state == OWN0) ? 2'b01 : (state == OWN1) ? 2'b10 : 2'b00;
        bus.core_coin   = core_coin_p1;
        bus.core_rstn   = core_rstn_p1;
        bus.sell0       = sell0_p1;
        bus.sell1       = sell1_p1;
        bus.change0     = change0_p1;
        bus.change1     = change1_p1;
        bus.refund_vld  = (state == FLUSH) && (credit != 3'd0);
        bus.refund_who  = bus.refund_vld && owner;
        bus.refund_amt  = bus.refund_vld ? credit : 3'd0;
    end
endmodule

// File: tb/tb_vend_arbiter.sv
// Directed, table-driven bench for vend_arbiter (TIMEOUT = 4); each row drives one
// cycle of inputs and lists the registered outputs expected during that cycle.
module tb_vend_arbiter;
    logic clk = 1'b0;
    logic rstn;
    vend_arbiter_if bus();

    vend_arbiter #(.TIMEOUT(4)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic [1:0]  r0;
        logic [1:0]  r1;
        logic        cs;
        logic [1:0]  cc;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    logic [15:0] obs;
    assign obs = {bus.gnt, bus.core_coin, bus.core_rstn, bus.sell0, bus.sell1,
                  bus.change0, bus.change1, bus.refund_vld, bus.refund_who, bus.refund_amt};

    // expected: gnt, core_coin, core_rstn, sell0, sell1, change0, change1, refund vld/who/amt
    task automatic add(input logic rs, input logic [1:0] r0, input logic [1:0] r1,
                       input logic cs, input logic [1:0] cc,
                       input logic [1:0] g, input logic [1:0] ccn, input logic cr,
                       input logic s0, input logic s1, input logic [1:0] c0, input logic [1:0] c1,
                       input logic rv, input logic rw, input logic [2:0] ra);
        vec_t v;
        v.rstn = rs; v.r0 = r0; v.r1 = r1; v.cs = cs; v.cc = cc;
        v.exp  = {g, ccn, cr, s0, s1, c0, c1, rv, rw, ra};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rs, input logic [1:0] r0, input logic [1:0] r1,
                         input logic cs, input logic [1:0] cc);
        rstn = rs; bus.req0_coin = r0; bus.req1_coin = r1;
        bus.core_sell = cs; bus.core_change = cc;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    initial begin
        bit seen;
        drive(1'b0, 2'b00, 2'b00, 1'b0, 2'b00);
        repeat (2) @(negedge clk);

        //   rs  r0 r1 cs cc     gnt cc  cr s0 s1 ch0 ch1 rv rw ra
        add(0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // T0 reset values
        add(1, 1, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // T1 req0 01 in IDLE
        add(1, 1, 0, 0, 0,      1, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T2 OWN0, accept
        add(1, 1, 0, 0, 0,      1, 1, 1, 0, 0, 0, 0, 0, 0, 0); // T3
        add(1, 1, 0, 0, 0,      1, 1, 1, 0, 0, 0, 0, 0, 0, 0); // T4 third coin
        add(1, 0, 0, 1, 0,      1, 1, 1, 0, 0, 0, 0, 0, 0, 0); // T5 core sells
        add(0, 0, 0, 0, 0,      0, 0, 1, 1, 0, 0, 0, 0, 0, 0); // T6 DONE, sell0
        add(1, 2, 2, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // T7 tie after reset
        add(1, 2, 2, 0, 0,      1, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T8 req0 wins
        add(1, 2, 2, 0, 0,      1, 2, 1, 0, 0, 0, 0, 0, 0, 0); // T9
        add(1, 0, 2, 1, 1,      1, 2, 1, 0, 0, 0, 0, 0, 0, 0); // T10 sell, change 01
        add(1, 0, 2, 0, 0,      0, 0, 1, 1, 0, 1, 0, 0, 0, 0); // T11 DONE
        add(1, 0, 2, 0, 0,      0, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T12 IDLE
        add(1, 0, 2, 0, 0,      2, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T13 OWN1, held coin
        add(1, 0, 1, 0, 0,      2, 2, 1, 0, 0, 0, 0, 0, 0, 0); // T14
        add(1, 0, 2, 0, 0,      2, 1, 1, 0, 0, 0, 0, 0, 0, 0); // T15
        add(1, 0, 0, 1, 1,      2, 2, 1, 0, 0, 0, 0, 0, 0, 0); // T16 sell, change 01
        add(1, 0, 1, 0, 0,      0, 0, 1, 0, 1, 0, 1, 0, 0, 0); // T17 sell1
        add(1, 0, 1, 0, 0,      0, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T18
        add(1, 0, 1, 0, 0,      2, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T19 accept, credit 1
        add(1, 1, 3, 0, 0,      2, 1, 1, 0, 0, 0, 0, 0, 0, 0); // T20 illegal + non-owner
        add(1, 1, 3, 0, 0,      2, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T21
        add(1, 1, 3, 0, 0,      2, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T22
        add(1, 1, 3, 0, 0,      2, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T23 timer at last
        add(1, 1, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 1, 1, 1); // T24 FLUSH, refund 1
        add(1, 1, 0, 0, 0,      0, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T25 IDLE
        add(1, 1, 0, 0, 0,      1, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T26 OWN0, accept
        add(1, 0, 0, 0, 0,      1, 1, 1, 0, 0, 0, 0, 0, 0, 0); // T27
        add(1, 0, 0, 0, 0,      1, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T28
        add(1, 0, 0, 0, 0,      1, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T29
        add(1, 0, 0, 0, 0,      1, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T30
        add(1, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 1, 0, 1); // T31 FLUSH req0
        add(1, 2, 0, 0, 0,      0, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T32
        add(1, 2, 0, 0, 0,      1, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T33 credit -> 2
        add(0, 0, 0, 0, 0,      1, 2, 1, 0, 0, 0, 0, 0, 0, 0); // T34 reset mid-txn
        add(1, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // T35 no refund
        add(1, 0, 0, 1, 1,      0, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T36 sell in IDLE
        add(1, 1, 1, 0, 0,      0, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T37 ignored; tie
        add(1, 1, 1, 0, 0,      1, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T38 req0 wins
        add(1, 0, 1, 1, 0,      1, 1, 1, 0, 0, 0, 0, 0, 0, 0); // T39 sell
        add(1, 1, 1, 0, 0,      0, 0, 1, 1, 0, 0, 0, 0, 0, 0); // T40 DONE
        add(1, 1, 1, 0, 0,      0, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T41 tie -> req1
        add(1, 1, 1, 0, 0,      2, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T42 accept req1
        add(1, 1, 0, 0, 0,      2, 1, 1, 0, 0, 0, 0, 0, 0, 0); // T43
        add(1, 1, 0, 0, 0,      2, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T44
        add(1, 1, 0, 0, 0,      2, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T45
        add(1, 1, 0, 1, 1,      2, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T46 timeout + sell
        add(1, 1, 0, 0, 0,      0, 0, 1, 0, 1, 0, 1, 0, 0, 0); // T47 sell wins
        add(1, 1, 0, 0, 0,      0, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T48
        add(1, 0, 0, 0, 0,      1, 0, 1, 0, 0, 0, 0, 0, 0, 0); // T49

        foreach (vecs[i]) begin
            drive(vecs[i].rstn, vecs[i].r0, vecs[i].r1, vecs[i].cs, vecs[i].cc);
            #1;
            check($sformatf("row%0d", i), obs, vecs[i].exp);
            @(negedge clk);
        end

        // Illegal coin in IDLE must not grant; a legal one must within a bounded wait.
        drive(1'b0, 2'b00, 2'b00, 1'b0, 2'b00);
        @(negedge clk);
        drive(1'b1, 2'b00, 2'b11, 1'b0, 2'b00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("illegal_idle%0d", k), {14'd0, bus.gnt}, 16'd0);
        end
        bus.req1_coin = 2'b10;
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(negedge clk);
            if (bus.gnt == 2'b10) seen = 1'b1;
        end
        check("grant_wait", {15'd0, seen}, 16'd1);
        @(negedge clk);
        bus.req1_coin = 2'b00;
        check("held_coin_fwd", {14'd0, bus.core_coin}, 16'd2);
        @(negedge clk);
        check("coin_one_cycle", {14'd0, bus.core_coin}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
